demux_2_sched: RTL
==================

DEMUX_2_SCHED -- requirements
Module: demux_2_sched

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, width of the data beat.
REQ-002 SHALL provide parameter CNT_WIDTH, default 16, width of each per-output packet counter.
REQ-003 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 soft_clr_i  input  1  synchronous clear, active-high.
REQ-006 mode_i  input  1  routing mode: 0 = round-robin per packet, 1 = explicit via dest_i.
REQ-007 dest_i  input  1  target output when mode_i = 1.
REQ-008 s_valid_i / s_data_i / s_last_i  input  1 / DATA_WIDTH / 1  upstream beat, qualifier, end-of-packet.
REQ-009 s_ready_o  output  1  upstream beat accepted when s_valid_i && s_ready_o.
REQ-010 m0_valid_o / m0_data_o / m0_last_o  output  1 / DATA_WIDTH / 1  output 0 beat.
REQ-011 m0_ready_i  input  1  output 0 backpressure.
REQ-012 m1_valid_o / m1_data_o / m1_last_o, m1_ready_i  same as output 0, for output 1.
REQ-013 busy_o  output  1  high while a packet is being routed (state ROUTE_0 or ROUTE_1).
REQ-014 sel_o  output  1  target of the current or most recent packet.
REQ-015 pkt_cnt_0_o / pkt_cnt_1_o  output  CNT_WIDTH  packets fully accepted per output.

Function
REQ-016 FSM states SHALL be IDLE, ROUTE_0, ROUTE_1.
REQ-017 IDLE: s_ready_o = 0; on s_valid_i = 1, SHALL latch target (mode_i ? dest_i : rr_ptr) into sel_o and enter ROUTE_<target> next cycle; one-cycle decision bubble per packet.
REQ-018 mode_i and dest_i SHALL be sampled only in IDLE; changes mid-packet SHALL be ignored.
REQ-019 ROUTE_x: s_ready_o = !mx_valid_o || mx_ready_i; the other output SHALL never receive beats.
REQ-020 Each output SHALL be a single register slice: an accepted beat appears on mx_* the next cycle (latency 1); mx_valid_o clears when mx_ready_i = 1 and no new beat is loaded.
REQ-021 Full throughput SHALL be sustained within a packet when mx_ready_i = 1 continuously.
REQ-022 mx_data_o/mx_last_o SHALL hold stable while mx_valid_o = 1 and mx_ready_i = 0.
REQ-023 Accepted beat with s_last_i = 1 in ROUTE_x: return to IDLE, pkt_cnt_x_o += 1, and in mode 0 rr_ptr = !x; in mode 1 rr_ptr SHALL be unchanged.
REQ-024 Single-beat packets (last on first beat) SHALL follow REQ-023 identically.
REQ-025 Counters SHALL wrap from 2^CNT_WIDTH-1 to 0.
REQ-026 Output slices SHALL drain independently of FSM state; a new packet to the other output may proceed while the previous output still holds a valid beat.
REQ-027 Outputs not carrying a valid beat SHALL drive data 0 and last 0; never high-impedance.
REQ-028 soft_clr_i SHALL take priority over all other events: next cycle state IDLE, mx_valid_o = 0, rr_ptr = 0, sel_o = 0, counters = 0; in-flight beats SHALL be discarded.

Reset
REQ-029 rst_n_i low SHALL immediately force: state IDLE, s_ready_o 0, m0/m1_valid_o 0, data/last 0, busy_o 0, sel_o 0, rr_ptr 0, both counters 0.
REQ-030 Reset mid-packet SHALL discard the packet; after release the block SHALL wait in IDLE for a new s_valid_i.

Verification
REQ-031 Mode 0, two 3-beat packets A0..A2 and B0..B2, both readies 1 -> A on output 0 with last on A2, B on output 1, one bubble between packets, pkt_cnt_0_o = pkt_cnt_1_o = 1.
REQ-032 Mode 1, dest_i = 1, dest_i toggled to 0 mid-packet -> all 4 beats on output 1, output 0 valid stays 0.
REQ-033 ROUTE_0, m0_ready_i = 0 for 5 cycles with slice full -> s_ready_o = 0, m0_data_o stable, no beat lost or duplicated after release.
REQ-034 CNT_WIDTH = 2, five single-beat packets in mode 1 dest 0 -> pkt_cnt_0_o sequence 1,2,3,0,1.
REQ-035 rst_n_i low during beat 2 of a 4-beat packet -> all outputs at reset values asynchronously; next packet routed to output 0 in mode 0.
REQ-036 soft_clr_i with s_valid_i = 1 and both slices valid -> next cycle both valids 0, state IDLE, counters 0.

Source files
------------

// File: rtl/demux_2_sched.sv
// demux_2_sched: routes whole packets to one of two register-sliced outputs, round-robin or by dest_i
module demux_2_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  soft_clr_i,
    input  logic                  mode_i,
    input  logic                  dest_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    output logic                  m0_valid_o,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_last_o,
    input  logic                  m0_ready_i,
    output logic                  m1_valid_o,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_last_o,
    input  logic                  m1_ready_i,
    output logic                  busy_o,
    output logic                  sel_o,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_0_o,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_1_o
);
    typedef enum logic [1:0] {IDLE, ROUTE_0, ROUTE_1} state_t;

    state_t                state_q, state_d;
    logic                  sel_q, sel_d, rr_q, rr_d, mode_q, mode_d;
    logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic                  v0_q, v0_d, l0_q, l0_d, v1_q, v1_d, l1_q, l1_d;
    logic [DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
    logic                  accept, load0, load1;

    // Packet FSM: pick a target in IDLE (mode latched so mid-packet changes are ignored), count packets on last
    always_comb begin
        s_ready_o = (state_q == ROUTE_0) ? (!v0_q || m0_ready_i) :
                    (state_q == ROUTE_1) ? (!v1_q || m1_ready_i) : 1'b0;
        accept    = s_valid_i && s_ready_o;
        load0     = accept && (state_q == ROUTE_0);
        load1     = accept && (state_q == ROUTE_1);
        state_d   = state_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        mode_d    = mode_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        if (state_q == IDLE && s_valid_i) begin
            sel_d   = mode_i ? dest_i : rr_q;
            mode_d  = mode_i;
            state_d = sel_d ? ROUTE_1 : ROUTE_0;
        end
        if (accept && s_last_i) begin
            state_d = IDLE;
            rr_d    = mode_q ? rr_q : (state_q == ROUTE_0);
            cnt0_d  = cnt0_q + CNT_WIDTH'(load0);
            cnt1_d  = cnt1_q + CNT_WIDTH'(load1);
        end
        if (soft_clr_i) begin
            state_d = IDLE;
            sel_d   = 1'b0;
            rr_d    = 1'b0;
            mode_d  = 1'b0;
            cnt0_d  = '0;
            cnt1_d  = '0;
        end
    end

    // Output slices drain on their own ready regardless of FSM state; empty slices read as zero
    always_comb begin
        v0_d = load0 || (v0_q && !m0_ready_i);
        d0_d = load0 ? s_data_i : (v0_d ? d0_q : '0);
        l0_d = load0 ? s_last_i : (v0_d && l0_q);
        v1_d = load1 || (v1_q && !m1_ready_i);
        d1_d = load1 ? s_data_i : (v1_d ? d1_q : '0);
        l1_d = load1 ? s_last_i : (v1_d && l1_q);
        if (soft_clr_i) begin
            v0_d = 1'b0;
            d0_d = '0;
            l0_d = 1'b0;
            v1_d = 1'b0;
            d1_d = '0;
            l1_d = 1'b0;
        end
    end

    // State and slice registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
            mode_q  <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            v0_q    <= 1'b0;
            d0_q    <= '0;
            l0_q    <= 1'b0;
            v1_q    <= 1'b0;
            d1_q    <= '0;
            l1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            mode_q  <= mode_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            v0_q    <= v0_d;
            d0_q    <= d0_d;
            l0_q    <= l0_d;
            v1_q    <= v1_d;
            d1_q    <= d1_d;
            l1_q    <= l1_d;
        end
    end

    assign m0_valid_o  = v0_q;
    assign m0_data_o   = d0_q;
    assign m0_last_o   = l0_q;
    assign m1_valid_o  = v1_q;
    assign m1_data_o   = d1_q;
    assign m1_last_o   = l1_q;
    assign busy_o      = (state_q != IDLE);
    assign sel_o       = sel_q;
    assign pkt_cnt_0_o = cnt0_q;
    assign pkt_cnt_1_o = cnt1_q;
endmodule
